// File: rtl/alu_share_sched_pkg.sv
// Shared definitions for the ALU time-share scheduler: opcodes, widths, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_sched_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ALU_OPW     = 4;
    localparam int ALU_NUM_OPS = 12;

    // Opcodes understood by the ALU that sits beside the scheduler
    localparam logic [ALU_OPW-1:0] ALU_ADD   = 4'd0;
    localparam logic [ALU_OPW-1:0] ALU_SUB   = 4'd1;
    localparam logic [ALU_OPW-1:0] ALU_AND   = 4'd2;
    localparam logic [ALU_OPW-1:0] ALU_OR    = 4'd3;
    localparam logic [ALU_OPW-1:0] ALU_XOR   = 4'd4;
    localparam logic [ALU_OPW-1:0] ALU_SLL   = 4'd5;
    localparam logic [ALU_OPW-1:0] ALU_SRL   = 4'd6;
    localparam logic [ALU_OPW-1:0] ALU_SRA   = 4'd7;
    localparam logic [ALU_OPW-1:0] ALU_SLT   = 4'd8;
    localparam logic [ALU_OPW-1:0] ALU_SLTU  = 4'd9;
    localparam logic [ALU_OPW-1:0] ALU_PASSA = 4'd10;
    localparam logic [ALU_OPW-1:0] ALU_PASSB = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

    // An opcode is legal when it falls inside 0..num_ops-1
    function automatic logic op_is_legal(input logic [7:0] op, input int num_ops);
        return int'(op) < num_ops;
    endfunction

endpackage

// File: rtl/alu_share_sched_if.sv
// One requester's channel: operation request plus its result return path.
// Latency: n/a (wiring only).
// Backpressure: req side valid/ready, rsp side valid/ready.
interface alu_share_sched_if
    import alu_share_sched_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = ALU_OPW
) ();

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_in1;
    logic [XLEN-1:0] req_in2;
    logic [OPW-1:0]  req_op;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    // Requester side
    modport master (
        output req_valid, req_in1, req_in2, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_in1, req_in2, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_share_sched.sv
// Round-robin time-share of one external combinational ALU between two requesters.
// Latency: handshake at T -> response valid at T+1+EXEC_CYCLES; one op in flight.
// Backpressure: no request accepted outside IDLE; response held until rsp_ready.
module alu_share_sched
    import alu_share_sched_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int OPW         = ALU_OPW,
    parameter int NUM_OPS     = ALU_NUM_OPS,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_sched_if.slave     req0,
    alu_share_sched_if.slave     req1,
    output logic [XLEN-1:0]      alu_in1,
    output logic [XLEN-1:0]      alu_in2,
    output logic [OPW-1:0]       alu_op,
    input  logic [XLEN-1:0]      alu_out,
    output logic                 busy
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    sched_state_t    state;
    logic            grant;
    logic            prio;
    logic [3:0]      exec_cnt;

    logic [XLEN-1:0] opnd_in1;
    logic [XLEN-1:0] opnd_in2;
    logic [OPW-1:0]  opnd_op;
    logic            opnd_err;
    logic [XLEN-1:0] result;

    logic            in_idle;
    logic            in_exec;
    logic            in_resp;
    logic            sel;
    logic            handshake;
    logic            exec_done;
    logic            rsp_take;
    logic [XLEN-1:0] new_in1;
    logic [XLEN-1:0] new_in2;
    logic [OPW-1:0]  new_op;

    assign in_idle = (state == ST_IDLE);
    assign in_exec = (state == ST_EXEC);
    assign in_resp = (state == ST_RESP);

    // Contention goes to prio; a lone requester wins outright
    assign sel = (req0.req_valid & req1.req_valid) ? prio : req1.req_valid;

    assign req0.req_ready = in_idle & ~sel;
    assign req1.req_ready = in_idle &  sel;
    assign handshake      = (req0.req_valid & req0.req_ready) |
                            (req1.req_valid & req1.req_ready);

    assign new_in1 = sel ? req1.req_in1 : req0.req_in1;
    assign new_in2 = sel ? req1.req_in2 : req0.req_in2;
    assign new_op  = sel ? req1.req_op  : req0.req_op;

    assign exec_done = in_exec & (exec_cnt == 4'd0);
    assign rsp_take  = in_resp & (grant ? req1.rsp_ready : req0.rsp_ready);

    // ALU sees the captured operands only while executing, zero otherwise
    assign alu_in1 = in_exec ? opnd_in1 : '0;
    assign alu_in2 = in_exec ? opnd_in2 : '0;
    assign alu_op  = in_exec ? opnd_op  : '0;

    // Response is presented only to the requester that owns the operation
    assign req0.rsp_valid = in_resp & ~grant;
    assign req1.rsp_valid = in_resp &  grant;
    assign req0.rsp_data  = req0.rsp_valid ? result : '0;
    assign req1.rsp_data  = req1.rsp_valid ? result : '0;
    assign req0.rsp_err   = req0.rsp_valid & opnd_err;
    assign req1.rsp_err   = req1.rsp_valid & opnd_err;

    assign busy = ~in_idle;

    // Scheduler FSM: arbitration, execute countdown, response wait, fairness flip
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            grant    <= 1'b0;
            prio     <= 1'b0;
            exec_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    grant <= sel;
                    if (handshake) begin
                        exec_cnt <= EXEC_LOAD;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_take) begin
                        prio  <= ~grant;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: capture operands at acceptance, capture ALU result at end of EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd_in1 <= '0;
            opnd_in2 <= '0;
            opnd_op  <= '0;
            opnd_err <= 1'b0;
            result   <= '0;
        end else begin
            if (handshake) begin
                opnd_in1 <= new_in1;
                opnd_in2 <= new_in2;
                opnd_op  <= new_op;
                opnd_err <= ~op_is_legal(8'(new_op), NUM_OPS);
            end
            if (exec_done) begin
                result <= opnd_err ? '0 : alu_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
// Randomised and directed bench for alu_share_sched with a behavioural ALU beside it.
// Latency: checks response exactly EXEC_CYCLES+1 cycles after acceptance.
// Backpressure: random response stalls, stray requests while busy.
module tb_alu_share_sched;
    import alu_share_sched_pkg::*;

    localparam int XLEN        = 32;
    localparam int OPW         = 4;
    localparam int NUM_OPS     = 12;
    localparam int EXEC_CYCLES = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_out;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;
    bit mdl_prio    = 1'b0;

    always #5 clk = ~clk;

    alu_share_sched_if #(.XLEN(XLEN), .OPW(OPW)) req0 ();
    alu_share_sched_if #(.XLEN(XLEN), .OPW(OPW)) req1 ();

    alu_share_sched #(
        .XLEN(XLEN), .OPW(OPW), .NUM_OPS(NUM_OPS), .EXEC_CYCLES(EXEC_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .busy(busy)
    );

    // Golden ALU; illegal opcodes return junk that the scheduler must not forward
    function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            4'd10:   return a;
            4'd11:   return b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_out = golden(alu_op, alu_in1, alu_in2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic quiet_inputs();
        req0.req_valid = 1'b0; req1.req_valid = 1'b0;
        req0.rsp_ready = 1'b0; req1.rsp_ready = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".rsp0_valid"}, req0.rsp_valid, 0);
        check({tag, ".rsp1_valid"}, req1.rsp_valid, 0);
        check({tag, ".rsp0_err"},   req0.rsp_err,   0);
        check({tag, ".rsp1_err"},   req1.rsp_err,   0);
        check({tag, ".busy"},       busy,           0);
        check({tag, ".alu_in1"},    alu_in1,        0);
        check({tag, ".alu_in2"},    alu_in2,        0);
        check({tag, ".alu_op"},     alu_op,         0);
    endtask

    // Called at a negedge: reset takes effect on the next edge, then idle is checked
    task automatic mid_reset(input string tag);
        reset = 1'b1;
        quiet_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mdl_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_quiet(tag);
            @(negedge clk);
        end
    endtask

    // One transaction from offer to consumption. rst_at: 0 none, 1..EXEC_CYCLES during
    // execution, EXEC_CYCLES+1 while the response is pending.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                           input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input int stall, input int rst_at);
        int          g;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        bit          err;
        @(negedge clk);
        req0.rsp_ready = 1'b0; req1.rsp_ready = 1'b0;
        req0.req_valid = v0; req0.req_op = op0; req0.req_in1 = a0; req0.req_in2 = b0;
        req1.req_valid = v1; req1.req_op = op1; req1.req_in1 = a1; req1.req_in2 = b1;
        #1;
        g = (v0 && v1) ? int'(mdl_prio) : (v1 ? 1 : 0);
        check("req0_ready", req0.req_ready, (g == 0) ? 1 : 0);
        check("req1_ready", req1.req_ready, (g == 1) ? 1 : 0);
        op  = (g == 1) ? op1 : op0;
        a   = (g == 1) ? a1  : a0;
        b   = (g == 1) ? b1  : b0;
        err = (int'(op) >= NUM_OPS);
        exp = err ? 32'd0 : golden(op, a, b);
        @(posedge clk);
        for (int k = 1; k <= EXEC_CYCLES; k++) begin
            @(negedge clk);
            req0.req_valid = 1'($urandom_range(0, 1));
            req1.req_valid = 1'($urandom_range(0, 1));
            #1;
            check("exec.busy", busy, 1);
            check("exec.rdy0", req0.req_ready, 0);
            check("exec.rdy1", req1.req_ready, 0);
            check("exec.rsp0", req0.rsp_valid, 0);
            check("exec.rsp1", req1.rsp_valid, 0);
            check("exec.in1",  alu_in1, a);
            check("exec.in2",  alu_in2, b);
            check("exec.op",   alu_op, op);
            if (rst_at == k) begin
                mid_reset("rst_exec");
                return;
            end
        end
        @(negedge clk);
        check("resp.valid_g", (g == 1) ? req1.rsp_valid : req0.rsp_valid, 1);
        check("resp.valid_o", (g == 1) ? req0.rsp_valid : req1.rsp_valid, 0);
        check("resp.data",    (g == 1) ? req1.rsp_data  : req0.rsp_data,  exp);
        check("resp.err",     (g == 1) ? req1.rsp_err   : req0.rsp_err,   err);
        check("resp.alu_in1", alu_in1, 0);
        check("resp.busy",    busy, 1);
        if (rst_at == EXEC_CYCLES + 1) begin
            mid_reset("rst_resp");
            return;
        end
        for (int s = 0; s < stall; s++) begin
            if (g == 1) req0.rsp_ready = 1'($urandom_range(0, 1));
            else        req1.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall.valid", (g == 1) ? req1.rsp_valid : req0.rsp_valid, 1);
            check("stall.data",  (g == 1) ? req1.rsp_data  : req0.rsp_data,  exp);
            check("stall.err",   (g == 1) ? req1.rsp_err   : req0.rsp_err,   err);
            check("stall.rdy0",  req0.req_ready, 0);
            check("stall.rdy1",  req1.req_ready, 0);
        end
        if (g == 1) req1.rsp_ready = 1'b1;
        else        req0.rsp_ready = 1'b1;
        @(posedge clk);
        mdl_prio = (g == 0);
        @(negedge clk);
        quiet_inputs();
        #1;
        check("done.busy", busy, 0);
        check("done.rsp0", req0.rsp_valid, 0);
        check("done.rsp1", req1.rsp_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        req0.req_op = '0; req0.req_in1 = '0; req0.req_in2 = '0;
        req1.req_op = '0; req1.req_in1 = '0; req1.req_in2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        // Single request
        run_txn(1, 0, ALU_ADD, 26, 13, ALU_SUB, 0, 0, 0, 0);
        // Contention straight after reset, repeated to see alternation
        mid_reset("pre_contend");
        run_txn(1, 1, ALU_ADD, 26, 13, ALU_SUB, 26, 13, 0, 0);
        run_txn(1, 1, ALU_ADD, 26, 13, ALU_SUB, 26, 13, 0, 0);
        run_txn(1, 1, ALU_ADD, 26, 13, ALU_SUB, 26, 13, 0, 0);
        // Backpressure on requester 1
        run_txn(0, 1, ALU_ADD, 1, 2, ALU_SUB, 26, 13, 5, 0);
        // Illegal opcode
        run_txn(1, 0, 4'd13, 26, 13, ALU_ADD, 0, 0, 0, 0);
        // Reset during EXEC and during RESP, each followed by contention
        run_txn(1, 0, ALU_ADD, 5, 6, ALU_ADD, 0, 0, 0, 0);
        run_txn(0, 1, ALU_XOR, 26, 13, ALU_OR, 26, 13, 0, 1);
        run_txn(1, 1, ALU_ADD, 26, 13, ALU_SUB, 26, 13, 0, 0);
        run_txn(1, 1, ALU_AND, 26, 13, ALU_OR, 26, 13, 0, EXEC_CYCLES + 1);
        run_txn(1, 1, ALU_ADD, 26, 13, ALU_SUB, 26, 13, 0, 0);
        // Opcode sweep with continuous contention
        for (int i = 0; i < NUM_OPS; i++) begin
            run_txn(1, 1, 4'(i), 26, 13, 4'(i), 26, 13, 0, 0);
        end
        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(v0, v1,
                    4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                    4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                    $urandom_range(0, 3), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
